// File: rtl/sample_mem_ctrl.sv
// rtl/sample_mem_ctrl.sv - triggered sample capture into a ring RAM with newest-first readout
// Strobed samples fill the ring until a trigger plus post-trigger delay, then the tail is streamed out.
module sample_mem_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] smpl_i,
    input  logic             trg_i,
    input  logic [15:0]      dly_cnt_i,
    input  logic [15:0]      rd_cnt_i,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [DEPTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_d_o,
    input  logic [WIDTH-1:0] mem_q_i,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CAP = 1 << DEPTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   rem_q, rem_d;
    logic [15:0]      post_q, post_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             done_q, done_d;
    logic [DEPTH:0]   rd_cap;

    // Readout length is clamped to the ring capacity.
    always_comb begin
        rd_cap = rd_cnt_i[DEPTH:0];
        if (rd_cnt_i >= 16'(CAP)) begin
            rd_cap = (DEPTH+1)'(CAP);
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rem_d      = rem_q;
        post_d     = post_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_d_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d  = S_ARMED;
                    wr_ptr_d = '0;
                end
            end
            S_ARMED: begin
                if (stb_i) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = wr_ptr_q;
                    mem_d_o    = smpl_i;
                    wr_ptr_d   = wr_ptr_q + DEPTH'(1);
                end
                if (trg_i) begin
                    state_d = S_DELAY;
                    post_d  = stb_i ? 16'd1 : 16'd0;
                end
            end
            S_DELAY: begin
                if (stb_i) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = wr_ptr_q;
                    mem_d_o    = smpl_i;
                    wr_ptr_d   = wr_ptr_q + DEPTH'(1);
                    if (post_q != 16'hFFFF) begin
                        post_d = post_q + 16'd1;
                    end
                end
                // Exit decision uses the registered count; a same-cycle strobe still lands in the ring.
                if (post_q >= dly_cnt_i) begin
                    rd_ptr_d = wr_ptr_d - DEPTH'(1);
                    rem_d    = rd_cap;
                    if (rd_cap == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_ptr_q;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_data_d = mem_q_i;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    rd_ptr_d = rd_ptr_q - DEPTH'(1);
                    rem_d    = rem_q - (DEPTH+1)'(1);
                    if (rem_q == (DEPTH+1)'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            post_q    <= '0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            post_q    <= post_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = (state_q == S_SEND);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_sample_mem_ctrl.sv
// tb/tb_sample_mem_ctrl.sv - scoreboard bench for sample_mem_ctrl with a behavioural RAM
module tb_sample_mem_ctrl;

    localparam int W = 32;
    localparam int D = 5;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, run, stb, trg, tx_ready;
    logic [W-1:0] smpl;
    logic [15:0]  dly, rdc;
    logic         mem_en, mem_we;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_d, mem_q, tx_data;
    logic         tx_valid, busy, done;

    always #5 clk = ~clk;

    sample_mem_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .run_i      (run),
        .stb_i      (stb),
        .smpl_i     (smpl),
        .trg_i      (trg),
        .dly_cnt_i  (dly),
        .rd_cnt_i   (rdc),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_d_o    (mem_d),
        .mem_q_i    (mem_q),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    logic [W-1:0] ram [N];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_d;
            else        mem_q <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int sent = 0;
    int done_cnt = 0;
    int wptr = 0;
    logic [W-1:0] model_mem [N];
    logic [W-1:0] exp_tx [$];
    logic [D-1:0] exp_wa [$];
    logic [W-1:0] exp_wd [$];

    typedef struct {
        int n_pre;
        int trg_stb;
        int n_post;
        int dly;
        int rd;
        int bp;
        int exp_words;
    } scn_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            if (exp_wa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %0d expected=no write", mem_addr);
            end else begin
                chk("wr_addr", 64'(mem_addr), 64'(exp_wa.pop_front()));
                chk("wr_data", 64'(mem_d), 64'(exp_wd.pop_front()));
            end
        end
        if (tx_valid && tx_ready) begin
            sent++;
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx actual=%0h expected=no word", tx_data);
            end else begin
                chk("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
        end
        if (done) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v, input logic t);
        stb  = 1'b1;
        trg  = t;
        smpl = 32'(v);
        exp_wa.push_back(D'(wptr));
        exp_wd.push_back(32'(v));
        model_mem[wptr] = 32'(v);
        wptr = (wptr + 1) % N;
        cyc();
    endtask

    task automatic push_reads(input int n);
        for (int k = 0; k < n; k++) begin
            exp_tx.push_back(model_mem[((wptr - 1 - k) % N + N) % N]);
        end
    endtask

    task automatic arm();
        run = 1'b1;
        cyc();
        run = 1'b0;
        wptr = 0;
    endtask

    task automatic wait_done(input int bp, input int exp_words);
        int d0 = done_cnt;
        int s0 = sent;
        int hold = 0;
        logic [W-1:0] held = '0;
        bit ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            if (bp == 1) begin
                tx_ready = 1'($urandom_range(0, 1));
            end else if (bp == 2 && (hold > 0 || tx_valid) && hold < 6) begin
                if (hold == 0) held = tx_data;
                else begin
                    chk("bp_valid", 64'(tx_valid), 64'd1);
                    chk("bp_data", 64'(tx_data), 64'(held));
                end
                hold++;
                tx_ready = 1'b0;
            end else begin
                tx_ready = 1'b1;
            end
            cyc();
        end
        tx_ready = 1'b1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done expected=done pulse");
        end
        chk("words_sent", 64'(sent - s0), 64'(exp_words));
        cyc();
        cyc();
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("tx_q_empty", 64'(exp_tx.size()), 64'd0);
        chk("wr_q_empty", 64'(exp_wa.size()), 64'd0);
    endtask

    task automatic run_scn(input scn_t s, input int base);
        int v = base;
        dly = 16'(s.dly);
        rdc = 16'(s.rd);
        tx_ready = 1'b1;
        arm();
        for (int i = 0; i < s.n_pre; i++) strobe(v++, 1'b0);
        if (s.trg_stb != 0) begin
            strobe(v++, 1'b1);
        end else begin
            stb = 1'b0;
            trg = 1'b1;
            cyc();
        end
        for (int i = 0; i < s.n_post; i++) strobe(v++, 1'b0);
        stb = 1'b0;
        trg = 1'b0;
        push_reads((s.rd < N) ? s.rd : N);
        wait_done(s.bp, s.exp_words);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    scn_t tbl [6];

    initial begin
        tbl[0] = '{10, 1, 2, 3, 4, 0, 4};
        tbl[1] = '{40, 1, 0, 1, 40, 0, 32};
        tbl[2] = '{5, 1, 1, 2, 0, 0, 0};
        tbl[3] = '{2, 0, 1, 1, 6, 1, 6};
        tbl[4] = '{3, 1, 2, 3, 5, 2, 5};
        tbl[5] = '{7, 1, 3, 4, 8, 1, 8};

        for (int i = 0; i < N; i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end
        rst = 1'b1; run = 1'b0; stb = 1'b0; trg = 1'b0; tx_ready = 1'b1;
        smpl = '0; dly = '0; rdc = '0;
        cyc(); cyc(); cyc();
        chk_quiet("reset");
        chk("reset_tx_data", 64'(tx_data), 64'd0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 6; i++) begin
            run_scn(tbl[i], (i == 0 || i == 1) ? 0 : 100 * i);
        end

        // dly_cnt=0 with a bare trigger reaches the read request two cycles on
        dly = 16'd0;
        rdc = 16'd1;
        arm();
        stb = 1'b0;
        trg = 1'b1;
        cyc();
        trg = 1'b0;
        push_reads(1);
        @(negedge clk);
        chk("dly0_delay_mem_en", 64'(mem_en), 64'd0);
        chk("dly0_delay_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dly0_rdreq_en", 64'(mem_en), 64'd1);
        chk("dly0_rdreq_we", 64'(mem_we), 64'd0);
        chk("dly0_rdreq_addr", 64'(mem_addr), 64'd31);
        wait_done(0, 1);

        // reset while a word is being offered
        dly = 16'd1;
        rdc = 16'd4;
        arm();
        tx_ready = 1'b0;
        strobe(77, 1'b1);
        stb = 1'b0;
        trg = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (tx_valid) begin
                    seen = 1'b1;
                    break;
                end
                cyc();
            end
            chk("send_reached", 64'(seen), 64'd1);
        end
        rst = 1'b1;
        cyc();
        chk_quiet("rst_send");
        chk("rst_send_tx_data", 64'(tx_data), 64'd0);
        stb = 1'b1;
        trg = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_tx.delete();
        tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        stb = 1'b0;
        trg = 1'b0;

        // reset while armed
        arm();
        strobe(5, 1'b0);
        stb = 1'b0;
        rst = 1'b1;
        cyc();
        stb = 1'b1;
        cyc();
        cyc();
        chk_quiet("rst_armed");
        rst = 1'b0;
        cyc();
        cyc();
        chk("rst_armed_stays_idle", 64'(busy), 64'd0);
        stb = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_mem_ctrl.md
SAMPLE_MEM_CTRL -- requirements
Module: sample_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the sample and RAM word width in bits.
REQ-002 SHALL have parameter DEPTH, default 5, the RAM address width; capacity is 2^DEPTH words.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  system clock; rst_i  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: run_i  in  1  arm pulse; stb_i  in  1  sample strobe; smpl_i  in  WIDTH  sample data; trg_i  in  1  trigger hit.
REQ-005 SHALL have ports: dly_cnt_i  in  16  post-trigger sample count; rd_cnt_i  in  16  readout word count.
REQ-006 SHALL have RAM ports: mem_en_o  out  1; mem_we_o  out  1; mem_addr_o  out  DEPTH; mem_d_o  out  WIDTH; mem_q_i  in  WIDTH (read data valid one cycle after the read request).
REQ-007 SHALL have transmit ports: tx_data_o  out  WIDTH; tx_valid_o  out  1; tx_ready_i  in  1; busy_o  out  1; done_o  out  1.

Function
REQ-008 SHALL implement states IDLE, ARMED, DELAY, RD_REQ, RD_WAIT, SEND.
REQ-009 IDLE: run_i=1 -> ARMED and wr_ptr:=0; all other inputs are ignored.
REQ-010 ARMED and DELAY: stb_i=1 -> mem_en_o=1, mem_we_o=1, mem_addr_o=wr_ptr, mem_d_o=smpl_i, all combinational in the same cycle, and wr_ptr increments modulo 2^DEPTH.
REQ-011 ARMED: trg_i=1 -> DELAY, with post-trigger count:=1 if stb_i=1 in that cycle, else 0.
REQ-012 DELAY: each stb_i increments the post-trigger count, which saturates at 0xFFFF.
REQ-013 DELAY exits to RD_REQ when post-trigger count >= dly_cnt_i; the comparison is on the registered count, so dly_cnt_i=0 exits the cycle after the trigger.
REQ-014 On DELAY exit: rd_ptr:=wr_ptr-1 (modulo 2^DEPTH, newest sample); remaining:=min(rd_cnt_i, 2^DEPTH), width DEPTH+1.
REQ-015 On DELAY exit with remaining=0: go to IDLE and pulse done_o for one cycle.
REQ-016 RD_REQ: mem_en_o=1, mem_we_o=0, mem_addr_o=rd_ptr; next state RD_WAIT.
REQ-017 RD_WAIT: register mem_q_i into tx_data_o; next state SEND.
REQ-018 SEND: tx_valid_o=1, with tx_data_o stable until tx_ready_i=1.
REQ-019 SEND handshake (tx_valid_o=1 and tx_ready_i=1): rd_ptr decrements with wrap and remaining decrements.
REQ-020 After the SEND handshake: if remaining becomes 0 -> IDLE with a one-cycle done_o pulse; else -> RD_REQ.
REQ-021 Readout SHALL be newest-first; minimum throughput is one word per 3 cycles.
REQ-022 stb_i, trg_i and run_i SHALL be ignored outside the states where they are used; no RAM write occurs in RD_REQ, RD_WAIT or SEND.
REQ-023 mem_en_o=0 SHALL hold whenever no write or read is requested; mem_addr_o and mem_d_o are don't-care then.
REQ-024 busy_o=1 SHALL hold in every state except IDLE.
REQ-025 If fewer than rd_cnt_i samples were written, unwritten (stale) locations are read; this is not an error condition.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force IDLE from any state, including mid-SEND, and clear wr_ptr, rd_ptr, remaining, the post-trigger count and tx_data_o.
REQ-027 During and after reset: tx_valid_o=0, mem_en_o=0, mem_we_o=0, busy_o=0, done_o=0; a new run_i is required to re-arm.

Verification
REQ-028 Reset: assert rst_i 3 cycles in each state -> all outputs 0 on the following cycle, state IDLE.
REQ-029 Basic capture, DEPTH=5: run; strobe values 0..9; value 10 with trg_i; values 11 and 12; dly_cnt_i=3, rd_cnt_i=4 -> writes to addresses 0..12, then tx words 12,11,10,9 and one done_o pulse.
REQ-030 Wrap capture: strobe values 0..39 in ARMED; value 40 with trg_i; dly_cnt_i=1, rd_cnt_i=40 -> value 40 written at address 8; 32 words sent, 40 down to 9; done_o pulse.
REQ-031 Backpressure: hold tx_ready_i=0 for 5 cycles in SEND -> tx_valid_o=1 and tx_data_o unchanged throughout; no word lost or repeated.
REQ-032 Zero counts: rd_cnt_i=0 -> no tx_valid_o, done_o pulse after DELAY; dly_cnt_i=0 with trg_i and no stb_i -> RD_REQ two cycles after the trigger.
REQ-033 Reset mid-readout: assert rst_i while in SEND -> tx_valid_o=0 next cycle; stb_i and trg_i cause no writes until run_i.
